// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - CPU/DMA arbiter for the shared data-memory port
// BR/BG handshake, port mux, CPU stall and starvation-bounded grant revocation.
module dmem_bus_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int FETCH_SIZE   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_readM,
  input  logic                  cpu_writeM,
  input  logic [WORD_SIZE-1:0]  cpu_address,
  input  logic [FETCH_SIZE-1:0] cpu_wdata,
  output logic                  cpu_stall,
  input  logic                  BR,
  output logic                  BG,
  input  logic                  dma_writeM,
  input  logic [WORD_SIZE-1:0]  dma_address,
  input  logic [FETCH_SIZE-1:0] dma_wdata,
  output logic                  mem_readM,
  output logic                  mem_writeM,
  output logic [WORD_SIZE-1:0]  mem_address,
  output logic [FETCH_SIZE-1:0] mem_wdata,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           grant_count
);

  localparam logic [1:0] ST_CPU    = 2'd0;
  localparam logic [1:0] ST_DMA    = 2'd1;
  localparam logic [1:0] ST_REVOKE = 2'd2;

  localparam logic [15:0] REVOKE_AT = (STARVE_LIMIT == 0) ? 16'd0 : 16'(STARVE_LIMIT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] wait_cnt;
  logic        cpu_req;
  logic        dma_sel;
  logic        starved;
  logic        enter_dma;

  assign cpu_req   = cpu_readM | cpu_writeM;
  assign dma_sel   = (state == ST_DMA);
  assign starved   = (STARVE_LIMIT != 0) && cpu_req && (wait_cnt == REVOKE_AT);
  assign enter_dma = (state_nxt == ST_DMA) && (state != ST_DMA);

  always_comb begin
    state_nxt = ST_CPU;
    case (state)
      ST_CPU:    state_nxt = BR ? ST_DMA : ST_CPU;
      // Release wins over revocation when both happen on the same edge.
      ST_DMA:    state_nxt = !BR ? ST_CPU : (starved ? ST_REVOKE : ST_DMA);
      ST_REVOKE: state_nxt = BR ? ST_DMA : ST_CPU;
      default:   state_nxt = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_CPU;
      BG           <= 1'b0;
      wait_cnt     <= 16'd0;
      stall_cycles <= 16'd0;
      grant_count  <= 16'd0;
    end else begin
      state <= state_nxt;
      BG    <= (state_nxt == ST_DMA);
      if (enter_dma)
        wait_cnt <= 16'd0;
      else if (dma_sel && cpu_req && wait_cnt != 16'hFFFF)
        wait_cnt <= wait_cnt + 16'd1;
      if (enter_dma && grant_count != 16'hFFFF)
        grant_count <= grant_count + 16'd1;
      if (dma_sel && cpu_req && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

  // Strobes are gated by reset so an in-flight DMA write is dropped at once.
  assign mem_readM   = !reset && !dma_sel && cpu_readM;
  assign mem_writeM  = !reset && (dma_sel ? dma_writeM : cpu_writeM);
  assign mem_address = dma_sel ? dma_address : cpu_address;
  assign mem_wdata   = dma_sel ? dma_wdata : cpu_wdata;
  assign cpu_stall   = !reset && dma_sel && cpu_req;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - directed self-checking bench for dmem_bus_arbiter
module tb_dmem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_readM, cpu_writeM, BR, dma_writeM;
  logic [15:0] cpu_address, dma_address;
  logic [63:0] cpu_wdata, dma_wdata;

  logic        a_stall, a_bg, a_rd, a_wr;
  logic [15:0] a_addr, a_stc, a_gc;
  logic [63:0] a_wdata;
  logic        b_stall, b_bg, b_rd, b_wr;
  logic [15:0] b_addr, b_stc, b_gc;
  logic [63:0] b_wdata;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_bus_arbiter #(.WORD_SIZE(16), .FETCH_SIZE(64), .STARVE_LIMIT(4)) u_a (
    .clk(clk), .reset(reset),
    .cpu_readM(cpu_readM), .cpu_writeM(cpu_writeM), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_stall(a_stall), .BR(BR), .BG(a_bg),
    .dma_writeM(dma_writeM), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .mem_readM(a_rd), .mem_writeM(a_wr), .mem_address(a_addr), .mem_wdata(a_wdata),
    .stall_cycles(a_stc), .grant_count(a_gc)
  );

  dmem_bus_arbiter #(.WORD_SIZE(16), .FETCH_SIZE(64), .STARVE_LIMIT(0)) u_b (
    .clk(clk), .reset(reset),
    .cpu_readM(cpu_readM), .cpu_writeM(cpu_writeM), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_stall(b_stall), .BR(BR), .BG(b_bg),
    .dma_writeM(dma_writeM), .dma_address(dma_address), .dma_wdata(dma_wdata),
    .mem_readM(b_rd), .mem_writeM(b_wr), .mem_address(b_addr), .mem_wdata(b_wdata),
    .stall_cycles(b_stc), .grant_count(b_gc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_readM = 0; cpu_writeM = 0; BR = 0; dma_writeM = 0;
    cpu_address = 16'h0000; dma_address = 16'h0000;
    cpu_wdata = 64'h0; dma_wdata = 64'h0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    step(1);
    reset = 0;
  endtask

  initial begin
    // Reset held two cycles with BR and a CPU write pending
    idle_inputs();
    reset = 1; BR = 1; cpu_writeM = 1;
    cpu_address = 16'h1234; cpu_wdata = 64'hCAFE_0000_0000_BEEF;
    step(2);
    chk("rst_bg", a_bg, 0);
    chk("rst_wr", a_wr, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_gc", a_gc, 0);
    chk("rst_stc", a_stc, 0);
    chk("rst_addr", a_addr, 16'h1234);
    chk("rst_wdata", a_wdata, 64'hCAFE_0000_0000_BEEF);
    reset = 0;
    step(1);
    chk("rel_bg", a_bg, 1);
    chk("rel_gc", a_gc, 1);
    chk("rel_stall", a_stall, 1);
    chk("rel_wr_dma", a_wr, 0);

    // DMA burst of 12 writes with the CPU idle
    do_reset();
    BR = 1; dma_writeM = 1; cpu_address = 16'h0F00;
    step(1);
    for (int i = 0; i < 12; i++) begin
      dma_address = 16'h01F4 + 16'(i);
      dma_wdata = 64'h1000 + 64'(i);
      #1;
      chk("burst_addr", a_addr, 16'h01F4 + 16'(i));
      chk("burst_wdata", a_wdata, 64'h1000 + 64'(i));
      chk("burst_wr", a_wr, 1);
      if (i == 11) BR = 0;
      step(1);
    end
    dma_writeM = 0;
    #1;
    chk("burst_bg_off", a_bg, 0);
    chk("burst_addr_cpu", a_addr, 16'h0F00);
    chk("burst_gc", a_gc, 1);
    chk("burst_stc", a_stc, 0);

    // Starvation: CPU read held with BR held, limit 4
    do_reset();
    cpu_readM = 1; BR = 1; cpu_address = 16'h0042;
    #1;
    chk("both_cpu_stall", a_stall, 0);
    chk("both_cpu_rd", a_rd, 1);
    step(1);
    for (int k = 0; k < 4; k++) begin
      chk("starve_stall", a_stall, 1);
      chk("starve_bg", a_bg, 1);
      chk("starve_rd", a_rd, 0);
      step(1);
    end
    chk("revoke_bg", a_bg, 0);
    chk("revoke_stall", a_stall, 0);
    chk("revoke_rd", a_rd, 1);
    chk("revoke_gc", a_gc, 1);
    chk("revoke_stc", a_stc, 4);
    chk("nolimit_bg", b_bg, 1);
    step(1);
    chk("regrant_bg", a_bg, 1);
    chk("regrant_gc", a_gc, 2);
    chk("regrant_stc", a_stc, 4);
    chk("regrant_stall", a_stall, 1);

    // BR falls on the edge that would otherwise revoke
    do_reset();
    cpu_readM = 1; BR = 1;
    step(4);
    BR = 0;
    step(1);
    chk("prio_bg", a_bg, 0);
    chk("prio_rd", a_rd, 1);
    chk("prio_gc", a_gc, 1);
    chk("prio_stc", a_stc, 4);
    step(1);
    chk("prio_gc_hold", a_gc, 1);
    chk("prio_bg_hold", a_bg, 0);

    // Asynchronous reset in the middle of a DMA write
    do_reset();
    BR = 1; dma_writeM = 1; dma_address = 16'h0100; cpu_address = 16'h0777;
    step(1);
    chk("mid_wr_pre", a_wr, 1);
    chk("mid_bg_pre", a_bg, 1);
    #2 reset = 1;
    #1;
    chk("mid_bg", a_bg, 0);
    chk("mid_wr", a_wr, 0);
    chk("mid_addr", a_addr, 16'h0777);
    BR = 0; dma_writeM = 0;
    step(1);
    reset = 0;
    step(1);
    chk("mid_after_bg", a_bg, 0);
    chk("mid_after_gc", a_gc, 0);

    // Stall counter saturation with revocation disabled
    do_reset();
    cpu_readM = 1; BR = 1;
    step(1);
    step(65534);
    chk("sat_fffe", b_stc, 16'hFFFE);
    step(1);
    chk("sat_ffff", b_stc, 16'hFFFF);
    step(4500);
    chk("sat_hold", b_stc, 16'hFFFF);
    chk("sat_bg", b_bg, 1);
    chk("sat_gc", b_gc, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_bus_arbiter.md
# dmem_bus_arbiter

Arbiter for the shared data-memory port between the CPU and the DMA engine. It sequences the BR/BG handshake and multiplexes address, write strobe and write data onto the single memory data port. It stalls the CPU while the DMA owns the bus, and revokes the grant after a bounded number of starved CPU cycles. It sits between `cpu`/`DMA` and `Memory` in the top level and replaces their direct wiring on `d_*`.

## Interface
- `WORD_SIZE`, 16, address width
- `FETCH_SIZE`, 64, data width (one 4-word DMA burst line)
- `STARVE_LIMIT`, 4, consecutive stalled CPU cycles before the grant is revoked; 0 disables revocation
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_readM`  in  1  CPU data read request
- `cpu_writeM`  in  1  CPU data write request
- `cpu_address`  in  WORD_SIZE  CPU data address
- `cpu_wdata`  in  FETCH_SIZE  CPU write data
- `cpu_stall`  out  1  CPU must hold its request and not advance
- `BR`  in  1  bus request from DMA
- `BG`  out  1  bus grant to DMA (registered)
- `dma_writeM`  in  1  DMA write strobe
- `dma_address`  in  WORD_SIZE  DMA write address
- `dma_wdata`  in  FETCH_SIZE  DMA write data
- `mem_readM`  out  1  to `Memory` `d_readM`
- `mem_writeM`  out  1  to `Memory` `d_writeM`
- `mem_address`  out  WORD_SIZE  to `Memory` `d_address`
- `mem_wdata`  out  FETCH_SIZE  value driven on the `d_data` bus when `mem_writeM`=1
- `stall_cycles`  out  16  count of stalled CPU cycles, saturating
- `grant_count`  out  16  count of DMA grants, saturating

## Operation
- `cpu_req` = `cpu_readM` | `cpu_writeM`.
- There are three states: CPU (reset state), DMA and REVOKE. `BG` = 1 only in DMA.
- CPU state:
  - The memory port is muxed to the CPU; `cpu_stall` = 0.
  - If `BR`=1 at an edge, go to DMA. The CPU access in the sampled cycle completes normally.
- DMA state:
  - The memory port is muxed to the DMA: `mem_readM` = 0, `mem_writeM` = `dma_writeM`.
  - `cpu_stall` = `cpu_req`.
  - `wait_cnt` increments on each cycle with `cpu_req`=1. It clears on entry to DMA.
  - If `BR`=0 at an edge, go to CPU.
  - Otherwise, if `STARVE_LIMIT`≠0, `cpu_req`=1 and `wait_cnt` = `STARVE_LIMIT`-1, go to REVOKE.
  - `BR`=0 has priority over revoke.
- REVOKE state:
  - The memory port is muxed to the CPU; `cpu_stall` = 0; DMA strobes are ignored.
  - This state always lasts exactly one cycle. Next state is DMA (re-grant, `grant_count`+1) if `BR`=1, else CPU.
- The DMA must hold its current burst offset while `BG`=0 and resume on re-grant. The arbiter never stores DMA data.
- `grant_count` increments on each entry to DMA. `stall_cycles` increments on each DMA-state cycle with `cpu_req`=1. Both saturate at 0xFFFF.

## Timing
- Reset values: state CPU, `BG`=0, `wait_cnt`=0, both counters 0.
- During reset: `mem_readM`=`mem_writeM`=0, `cpu_stall`=0, `mem_address`/`mem_wdata` follow the CPU inputs.
- Grant latency: `BR` sampled high at edge N gives `BG`=1 after edge N.
- Release latency: `BR` sampled low gives `BG`=0 after the same edge.
- The mux select, `cpu_stall` and `mem_*` are combinational from the registered state. They change only at edges or on reset assertion.
- The maximum CPU stall per grant is `STARVE_LIMIT` cycles. After that the CPU is served in the REVOKE cycle.
- Reset asserted mid-DMA: `BG` drops and the mux returns to CPU immediately (asynchronously), with no end-of-cycle wait. A DMA write in flight is dropped.
- `BR` and `cpu_req` both high in CPU state: the CPU access completes this cycle and the DMA is granted next cycle.
- `STARVE_LIMIT`=1: REVOKE follows every DMA cycle in which the CPU requests.

## Test plan
- Reset held 2 cycles with `BR`=1, `cpu_writeM`=1 -> `BG`=0, `mem_writeM`=0, counters 0. After release, `BG`=1 one edge later.
- CPU idle, `BR` high 12 cycles with `dma_writeM`=1 at `dma_address` 0x01F4..0x01FF -> `mem_address` tracks the DMA, `grant_count`=1, `stall_cycles`=0, `BG`=0 one edge after `BR` falls.
- `STARVE_LIMIT`=4, `BR` held, `cpu_readM`=1 continuously -> `cpu_stall` high for exactly 4 cycles, then `BG`=0 for 1 cycle with `mem_readM`=1, then re-grant. `grant_count`=2 and `stall_cycles`=4 after the first revoke.
- `BR` drops on the same edge where `wait_cnt`=`STARVE_LIMIT`-1 -> next state CPU, no REVOKE cycle, `grant_count` unchanged.
- Reset pulsed mid-DMA burst -> `BG` and `mem_writeM` fall within the same time step, the memory location is not written, and the state is CPU.
- Force `stall_cycles` near saturation (`STARVE_LIMIT`=0, `cpu_req` high for 70000 DMA cycles) -> `stall_cycles` = 0xFFFF with no wrap.
